// File: rtl/det_mem_responder_if.sv
// Bus between the Det core / preload host (master) and det_mem_responder (slave).
//   Preload : load_en, load_addr[AW], load_data[N], start        master -> slave
//   Det req : read, write, i[N], j[N], write_data[2N], finish     master -> slave
//   Response: read_data[N], read_valid, result[2N], result_valid,
//             addr_err, wr_err                                     slave -> master
interface det_mem_responder_if #(
    parameter int N  = 20,
    parameter int AW = 10
);
    logic             load_en;
    logic [AW-1:0]    load_addr;
    logic [N-1:0]     load_data;
    logic             start;
    logic             read;
    logic             write;
    logic [N-1:0]     i;
    logic [N-1:0]     j;
    logic [2*N-1:0]   write_data;
    logic             finish;
    logic [N-1:0]     read_data;
    logic             read_valid;
    logic [2*N-1:0]   result;
    logic             result_valid;
    logic             addr_err;
    logic             wr_err;

    modport master (
        output load_en, load_addr, load_data, start,
        output read, write, i, j, write_data, finish,
        input  read_data, read_valid, result, result_valid, addr_err, wr_err
    );

    modport slave (
        input  load_en, load_addr, load_data, start,
        input  read, write, i, j, write_data, finish,
        output read_data, read_valid, result, result_valid, addr_err, wr_err
    );
endinterface

// File: rtl/det_mem_responder.sv
// Memory-side responder for the Det matrix engine.
// Holds the matrix image (word 0 = column count, row-major entries from word 1),
// serves Det reads addressed by (i,j) with one cycle of latency, and captures the
// signed determinant when finish rises.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low
//   bus    det_mem_responder_if.slave (preload, Det request and response signals)
module det_mem_responder #(
    parameter int N     = 20,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    det_mem_responder_if.slave   bus
);
    typedef enum logic [1:0] {S_LOAD, S_SERVE, S_DONE} state_t;

    localparam logic [2*N:0] LP_DEPTH = (2*N+1)'(DEPTH);

    state_t          r_state;
    logic [N-1:0]    r_column;
    logic            r_finish_q;
    logic [N-1:0]    r_mem [DEPTH];
    logic [N-1:0]    r_read_data;
    logic            r_read_valid;
    logic [2*N-1:0]  r_result;
    logic            r_result_valid;
    logic            r_addr_err;
    logic            r_wr_err;

    logic [2*N:0]    w_addr;
    logic            w_in_range;
    logic            w_finish_rise;
    logic [N-1:0]    w_col_src;

    // Full-width address so large (i,j) can never alias back into range.
    assign w_addr        = (2*N+1)'(bus.i) * (2*N+1)'(r_column)
                         + (2*N+1)'(bus.j) + (2*N+1)'(1);
    assign w_in_range    = (w_addr < LP_DEPTH);
    assign w_finish_rise = bus.finish && !r_finish_q;
    // A preload of word 0 in the start cycle must win over the stale memory word.
    assign w_col_src     = (bus.load_en && (bus.load_addr == '0)) ? bus.load_data : r_mem[0];

    // Memory is deliberately not reset; it survives a reset pulse.
    always_ff @(posedge clk) begin
        if (r_state == S_LOAD && bus.load_en)
            r_mem[bus.load_addr] <= bus.load_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= S_LOAD;
            r_column       <= '0;
            r_finish_q     <= 1'b0;
            r_read_data    <= '0;
            r_read_valid   <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_addr_err     <= 1'b0;
            r_wr_err       <= 1'b0;
        end else begin
            r_finish_q   <= bus.finish;
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    if (bus.start) begin
                        r_state  <= S_SERVE;
                        r_column <= w_col_src;
                    end
                end
                S_SERVE: begin
                    if (bus.read) begin
                        r_read_valid <= 1'b1;
                        if (bus.write)
                            r_read_data <= r_column;
                        else if (w_in_range)
                            r_read_data <= r_mem[w_addr[AW-1:0]];
                        else
                            r_addr_err  <= 1'b1;
                    end
                    if (w_finish_rise) begin
                        if (bus.write) begin
                            r_result       <= bus.write_data;
                            r_result_valid <= 1'b1;
                            r_state        <= S_DONE;
                        end else begin
                            r_wr_err <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.start) begin
                        r_state        <= S_SERVE;
                        r_result_valid <= 1'b0;
                        r_column       <= r_mem[0];
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    assign bus.read_data    = r_read_data;
    assign bus.read_valid   = r_read_valid;
    assign bus.result       = r_result;
    assign bus.result_valid = r_result_valid;
    assign bus.addr_err     = r_addr_err;
    assign bus.wr_err       = r_wr_err;
endmodule

// File: tb/tb_det_mem_responder.sv
// Scoreboard bench for det_mem_responder: each served read pushes its expected word,
// a monitor pops and compares whenever read_valid is seen; flags and result are
// checked directly against hand-computed values.
module tb_det_mem_responder;
    localparam int N     = 20;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    logic [N-1:0] sb_q [$];

    det_mem_responder_if #(.N(N), .AW(AW)) bus ();

    det_mem_responder #(.N(N), .DEPTH(DEPTH), .AW(AW)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every presented response against the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (reset && bus.read_valid) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_read_valid: got data %0h expected no response", bus.read_data);
                end else begin
                    check("read_data", 64'(bus.read_data), 64'(sb_q.pop_front()));
                end
            end
        end
    end

    task automatic load(input logic [AW-1:0] a, input logic [N-1:0] d);
        @(negedge clk);
        bus.load_en   = 1'b1;
        bus.load_addr = a;
        bus.load_data = d;
    endtask

    task automatic rd(input logic [N-1:0] ii, input logic [N-1:0] jj, input logic wr,
                      input logic [N-1:0] exp);
        @(negedge clk);
        bus.read  = 1'b1;
        bus.write = wr;
        bus.i     = ii;
        bus.j     = jj;
        sb_q.push_back(exp);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.read  = 1'b0;
        bus.write = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_read_valid"},   64'(bus.read_valid),   64'd0);
        check({tag, "_read_data"},    64'(bus.read_data),    64'd0);
        check({tag, "_result"},       64'(bus.result),       64'd0);
        check({tag, "_result_valid"}, 64'(bus.result_valid), 64'd0);
        check({tag, "_addr_err"},     64'(bus.addr_err),     64'd0);
        check({tag, "_wr_err"},       64'(bus.wr_err),       64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        bus.load_en = 1'b0; bus.load_addr = '0; bus.load_data = '0; bus.start = 1'b0;
        bus.read = 1'b0; bus.write = 1'b0; bus.i = '0; bus.j = '0;
        bus.write_data = '0; bus.finish = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        // Preload; word 0 first written as 5, then overridden by the bypass at start.
        load(0, 5); load(1, 3); load(2, 1); load(3, 4); load(4, 2); load(1023, 77);
        @(negedge clk);
        bus.load_en = 1'b1; bus.load_addr = '0; bus.load_data = 2; bus.start = 1'b1;
        @(negedge clk);
        bus.load_en = 1'b0; bus.start = 1'b0;

        rd(1, 0, 1'b0, 4);      // addr 3
        rd(0, 0, 1'b0, 3);      // addr 1
        rd(1, 1, 1'b0, 2);      // addr 4
        rd(0, 0, 1'b1, 2);      // column query
        rd(511, 0, 1'b0, 77);   // addr 1023, last in range
        idle();
        check("addr_err_before", 64'(bus.addr_err), 64'd0);
        rd(600, 0, 1'b0, 0);    // addr 1201
        idle();
        check("addr_err_set", 64'(bus.addr_err), 64'd1);
        rd(511, 1, 1'b0, 0);    // addr 1024, first out of range
        rd(524288, 0, 1'b0, 0); // 2^20+1: aliases to 1 if truncated
        rd(0, 1, 1'b0, 1);      // addr 2
        idle();
        check("addr_err_sticky", 64'(bus.addr_err), 64'd1);

        // finish rises with write=0, read served in the same cycle.
        @(negedge clk);
        bus.read = 1'b1; bus.write = 1'b0; bus.i = 1; bus.j = 0; bus.finish = 1'b1;
        sb_q.push_back(4);
        idle();
        check("wr_err_set", 64'(bus.wr_err), 64'd1);
        check("result_valid_after_wr_err", 64'(bus.result_valid), 64'd0);
        @(negedge clk);
        bus.write = 1'b1; bus.write_data = 40'hFF_FFFF_FFFE;   // finish still high: no edge
        @(negedge clk);
        check("no_edge_result_valid", 64'(bus.result_valid), 64'd0);
        bus.finish = 1'b0; bus.write = 1'b0;

        // Real completion: result = -2.
        @(negedge clk);
        bus.finish = 1'b1; bus.write = 1'b1; bus.write_data = 40'hFF_FFFF_FFFE;
        @(negedge clk);
        bus.finish = 1'b0; bus.write = 1'b0;
        check("result", 64'(bus.result), 64'hFF_FFFF_FFFE);
        check("result_valid", 64'(bus.result_valid), 64'd1);
        @(negedge clk);
        bus.read = 1'b1; bus.i = 1; bus.j = 0;                 // DONE: not served
        @(negedge clk);
        bus.read = 1'b0;
        check("done_read_valid", 64'(bus.read_valid), 64'd0);

        // Restart from DONE.
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("restart_result_valid", 64'(bus.result_valid), 64'd0);
        check("restart_result_held", 64'(bus.result), 64'hFF_FFFF_FFFE);
        rd(0, 0, 1'b1, 2);
        idle();

        // Asynchronous reset mid-SERVE while a response is on the outputs.
        @(negedge clk);
        bus.read = 1'b1; bus.write = 1'b0; bus.i = 0; bus.j = 0;
        @(posedge clk);
        #1;
        check("pre_reset_read_valid", 64'(bus.read_valid), 64'd1);
        check("pre_reset_read_data", 64'(bus.read_data), 64'd3);
        bus.read = 1'b0;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        bus.finish = 1'b1; bus.write = 1'b1;                   // high on SERVE entry: no edge
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("finish_high_on_entry", 64'(bus.result_valid), 64'd0);
        bus.finish = 1'b0; bus.write = 1'b0;
        rd(0, 1, 1'b0, 1);
        rd(0, 0, 1'b1, 2);
        idle();
        check("post_reset_addr_err", 64'(bus.addr_err), 64'd0);
        check("post_reset_wr_err", 64'(bus.wr_err), 64'd0);
        @(negedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
